// File: rtl/expipe_pkg.sv
// Shared definitions for the FP misc execution pipe: op encoding, exception codes,
// FCLASS bit positions and canonical NaN patterns.
package expipe_pkg;

    typedef enum logic [3:0] {
        OP_FSGNJ  = 4'd0,
        OP_FSGNJN = 4'd1,
        OP_FSGNJX = 4'd2,
        OP_FMIN   = 4'd3,
        OP_FMAX   = 4'd4,
        OP_FEQ    = 4'd5,
        OP_FLT    = 4'd6,
        OP_FLE    = 4'd7,
        OP_FCLASS = 4'd8,
        OP_FMV_X  = 4'd9,
        OP_FMV_F  = 4'd10
    } fp_misc_op_t;

    localparam int unsigned E_ILLEGAL = 1;

    localparam int unsigned FCLASS_NEG_INF  = 0;
    localparam int unsigned FCLASS_NEG_NORM = 1;
    localparam int unsigned FCLASS_NEG_SUB  = 2;
    localparam int unsigned FCLASS_NEG_ZERO = 3;
    localparam int unsigned FCLASS_POS_ZERO = 4;
    localparam int unsigned FCLASS_POS_SUB  = 5;
    localparam int unsigned FCLASS_POS_NORM = 6;
    localparam int unsigned FCLASS_POS_INF  = 7;
    localparam int unsigned FCLASS_SNAN     = 8;
    localparam int unsigned FCLASS_QNAN     = 9;

    localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    function automatic logic [63:0] canon_nan(input int unsigned flen);
        return (flen == 32) ? {32'h0, CANON_NAN_S} : CANON_NAN_D;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one FP operand, substituting canonical qNaN for an
// improperly NaN-boxed value. is_snan exists only with FP_MISC_PIPE_FFLAGS_EN.
module fp_classify
    import expipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int FLEN = 32
) (
    input  logic [XLEN-1:0] operand,
    output logic [FLEN-1:0] value,
    output logic            sign,
    output logic            exp_all1,
    output logic            exp_zero,
    output logic            man_zero,
    output logic            is_nan,
`ifdef FP_MISC_PIPE_FFLAGS_EN
    output logic            is_snan,
`endif
    output logic [9:0]      class_onehot
);
    localparam int EXP_W = (FLEN == 32) ? 8 : 11;
    localparam int MAN_W = FLEN - 1 - EXP_W;
    localparam logic [FLEN-1:0] CANON = FLEN'(canon_nan(FLEN));

    logic boxed;
    logic quiet;

    generate
        if (FLEN < XLEN) begin : g_box
            assign boxed = &operand[XLEN-1:FLEN];
        end else begin : g_nobox
            assign boxed = 1'b1;
        end
    endgenerate

    assign value    = boxed ? operand[FLEN-1:0] : CANON;
    assign sign     = value[FLEN-1];
    assign exp_all1 = &value[FLEN-2 -: EXP_W];
    assign exp_zero = ~|value[FLEN-2 -: EXP_W];
    assign man_zero = ~|value[MAN_W-1:0];
    assign quiet    = value[MAN_W-1];
    assign is_nan   = exp_all1 & ~man_zero;
`ifdef FP_MISC_PIPE_FFLAGS_EN
    assign is_snan  = is_nan & ~quiet;
`endif

    always_comb begin
        class_onehot = '0;
        class_onehot[FCLASS_NEG_INF]  = sign & exp_all1 & man_zero;
        class_onehot[FCLASS_NEG_NORM] = sign & ~exp_all1 & ~exp_zero;
        class_onehot[FCLASS_NEG_SUB]  = sign & exp_zero & ~man_zero;
        class_onehot[FCLASS_NEG_ZERO] = sign & exp_zero & man_zero;
        class_onehot[FCLASS_POS_ZERO] = ~sign & exp_zero & man_zero;
        class_onehot[FCLASS_POS_SUB]  = ~sign & exp_zero & ~man_zero;
        class_onehot[FCLASS_POS_NORM] = ~sign & ~exp_all1 & ~exp_zero;
        class_onehot[FCLASS_POS_INF]  = ~sign & exp_all1 & man_zero;
        class_onehot[FCLASS_SNAN]     = is_nan & ~quiet;
        class_onehot[FCLASS_QNAN]     = is_nan & quiet;
    end

endmodule

// File: rtl/fp_misc_pipe.sv
// Pipelined non-arithmetic RV F/D unit (sign-inject, min/max, compare, classify, moves).
// Optional accrued-flag output enabled by FP_MISC_PIPE_FFLAGS_EN.
module fp_misc_pipe
    import expipe_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int FLEN       = 32,
    parameter int RS_DEPTH   = 4,
    parameter int EU_CTL_LEN = 4,
    parameter int EXCEPT_LEN = 2,
    parameter int LATENCY    = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        flush_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [EU_CTL_LEN-1:0]       ctl_i,
    input  logic [XLEN-1:0]             rs1_i,
    input  logic [XLEN-1:0]             rs2_i,
    input  logic [$clog2(RS_DEPTH)-1:0] entry_idx_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(RS_DEPTH)-1:0] entry_idx_o,
    output logic [XLEN-1:0]             result_o,
    output logic                        except_raised_o,
    output logic [EXCEPT_LEN-1:0]       except_code_o
`ifdef FP_MISC_PIPE_FFLAGS_EN
    ,output logic [4:0]                 fflags_o
`endif
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam logic [XLEN-1:0] BOX = (FLEN < XLEN) ? ({XLEN{1'b1}} << FLEN) : '0;
    localparam logic [FLEN-1:0] CANON = FLEN'(canon_nan(FLEN));

    logic [FLEN-1:0] a_val, b_val;
    logic            a_sign, b_sign, a_all1, b_all1, a_ezero, b_ezero;
    logic            a_mzero, b_mzero, a_nan, b_nan;
    logic [9:0]      a_class, b_class;
`ifdef FP_MISC_PIPE_FFLAGS_EN
    logic            a_snan, b_snan;
`endif

    fp_classify #(.XLEN(XLEN), .FLEN(FLEN)) u_cls_a (
        .operand(rs1_i), .value(a_val), .sign(a_sign), .exp_all1(a_all1),
        .exp_zero(a_ezero), .man_zero(a_mzero), .is_nan(a_nan),
`ifdef FP_MISC_PIPE_FFLAGS_EN
        .is_snan(a_snan),
`endif
        .class_onehot(a_class)
    );

    fp_classify #(.XLEN(XLEN), .FLEN(FLEN)) u_cls_b (
        .operand(rs2_i), .value(b_val), .sign(b_sign), .exp_all1(b_all1),
        .exp_zero(b_ezero), .man_zero(b_mzero), .is_nan(b_nan),
`ifdef FP_MISC_PIPE_FFLAGS_EN
        .is_snan(b_snan),
`endif
        .class_onehot(b_class)
    );

    logic unused_cls;
    assign unused_cls = ^{a_all1, b_all1, b_class};

    // Total order used by min/max: -0 sorts below +0; NaNs are filtered beforehand.
    function automatic logic lt_total(input logic [FLEN-1:0] x, input logic [FLEN-1:0] y);
        if (x[FLEN-1] != y[FLEN-1]) return x[FLEN-1];
        if (x[FLEN-1])              return x[FLEN-2:0] > y[FLEN-2:0];
        return x[FLEN-2:0] < y[FLEN-2:0];
    endfunction

    function automatic logic [XLEN-1:0] box(input logic [FLEN-1:0] v);
        return BOX | XLEN'(v);
    endfunction

    fp_misc_op_t           op;
    logic                  legal, any_nan, both_zero, lt, eq;
    logic [XLEN-1:0]       res_d;
    logic                  exc_d;
    logic [EXCEPT_LEN-1:0] code_d;
`ifdef FP_MISC_PIPE_FFLAGS_EN
    logic                  nv_d;
`endif

    assign op        = fp_misc_op_t'(ctl_i[3:0]);
    assign legal     = (ctl_i <= EU_CTL_LEN'(OP_FMV_F));
    assign any_nan   = a_nan | b_nan;
    assign both_zero = a_ezero & a_mzero & b_ezero & b_mzero;
    assign lt        = lt_total(a_val, b_val);
    assign eq        = (a_val == b_val) | both_zero;

    always_comb begin
        res_d  = '0;
        exc_d  = 1'b0;
        code_d = '0;
`ifdef FP_MISC_PIPE_FFLAGS_EN
        nv_d   = 1'b0;
`endif
        if (!legal) begin
            exc_d  = 1'b1;
            code_d = EXCEPT_LEN'(E_ILLEGAL);
        end else begin
            case (op)
                OP_FSGNJ:  res_d = box({b_sign, a_val[FLEN-2:0]});
                OP_FSGNJN: res_d = box({~b_sign, a_val[FLEN-2:0]});
                OP_FSGNJX: res_d = box({a_sign ^ b_sign, a_val[FLEN-2:0]});
                OP_FMIN, OP_FMAX: begin
                    if (a_nan && b_nan)    res_d = box(CANON);
                    else if (a_nan)        res_d = box(b_val);
                    else if (b_nan)        res_d = box(a_val);
                    else if (lt ^ (op == OP_FMAX)) res_d = box(a_val);
                    else                   res_d = box(b_val);
`ifdef FP_MISC_PIPE_FFLAGS_EN
                    nv_d = a_snan | b_snan;
`endif
                end
                OP_FEQ: begin
                    res_d = XLEN'(~any_nan & eq);
`ifdef FP_MISC_PIPE_FFLAGS_EN
                    nv_d  = a_snan | b_snan;
`endif
                end
                OP_FLT, OP_FLE: begin
                    if (op == OP_FLT) res_d = XLEN'(~any_nan & lt & ~both_zero);
                    else              res_d = XLEN'(~any_nan & (lt | eq));
`ifdef FP_MISC_PIPE_FFLAGS_EN
                    nv_d = any_nan;
`endif
                end
                OP_FCLASS: res_d = XLEN'(a_class);
                OP_FMV_X:  res_d = rs1_i[FLEN-1] ? box(rs1_i[FLEN-1:0]) : XLEN'(rs1_i[FLEN-1:0]);
                OP_FMV_F:  res_d = box(rs1_i[FLEN-1:0]);
                default:   res_d = '0;
            endcase
        end
    end

    logic                  enable;
    logic                  vld_p  [LATENCY];
    logic [XLEN-1:0]       res_p  [LATENCY];
    logic [IDX_W-1:0]      idx_p  [LATENCY];
    logic                  exc_p  [LATENCY];
    logic [EXCEPT_LEN-1:0] code_p [LATENCY];
`ifdef FP_MISC_PIPE_FFLAGS_EN
    logic                  nv_p   [LATENCY];
`endif

    assign enable  = !valid_o || ready_i;
    assign ready_o = enable;

    // Stage boundaries: stage 0 captures the computed result, later stages just shift.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                res_p[i]  <= '0;
                idx_p[i]  <= '0;
                exc_p[i]  <= 1'b0;
                code_p[i] <= '0;
`ifdef FP_MISC_PIPE_FFLAGS_EN
                nv_p[i]   <= 1'b0;
`endif
            end
        end else begin
            if (enable) begin
                vld_p[0]  <= valid_i;
                res_p[0]  <= res_d;
                idx_p[0]  <= entry_idx_i;
                exc_p[0]  <= exc_d;
                code_p[0] <= code_d;
`ifdef FP_MISC_PIPE_FFLAGS_EN
                nv_p[0]   <= nv_d;
`endif
                for (int i = 1; i < LATENCY; i++) begin
                    vld_p[i]  <= vld_p[i-1];
                    res_p[i]  <= res_p[i-1];
                    idx_p[i]  <= idx_p[i-1];
                    exc_p[i]  <= exc_p[i-1];
                    code_p[i] <= code_p[i-1];
`ifdef FP_MISC_PIPE_FFLAGS_EN
                    nv_p[i]   <= nv_p[i-1];
`endif
                end
            end
            if (flush_i) begin
                for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
            end
        end
    end

    assign valid_o         = vld_p[LATENCY-1];
    assign result_o        = res_p[LATENCY-1];
    assign entry_idx_o     = idx_p[LATENCY-1];
    assign except_raised_o = exc_p[LATENCY-1];
    assign except_code_o   = code_p[LATENCY-1];
`ifdef FP_MISC_PIPE_FFLAGS_EN
    assign fflags_o        = {nv_p[LATENCY-1], 4'b0000};
`endif

endmodule

// File: tb/tb_fp_misc_pipe.sv
// Directed bench for fp_misc_pipe (FLEN=32, XLEN=64, LATENCY=2); NV checks are
// compiled in only when FP_MISC_PIPE_FFLAGS_EN is defined.
module tb_fp_misc_pipe;
    localparam int XLEN = 64, FLEN = 32, RS_DEPTH = 4, EU_CTL_LEN = 4, EXCEPT_LEN = 2, LATENCY = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  valid_in = 1'b0;
    logic                  ready_out;
    logic [EU_CTL_LEN-1:0] ctl = '0;
    logic [XLEN-1:0]       rs1 = '0, rs2 = '0;
    logic [1:0]            idx_in = '0;
    logic                  valid_out;
    logic                  ready_in = 1'b1;
    logic [1:0]            idx_out;
    logic [XLEN-1:0]       result;
    logic                  exc;
    logic [EXCEPT_LEN-1:0] exc_code;
`ifdef FP_MISC_PIPE_FFLAGS_EN
    logic [4:0]            fflags;
`endif

    fp_misc_pipe #(.XLEN(XLEN), .FLEN(FLEN), .RS_DEPTH(RS_DEPTH), .EU_CTL_LEN(EU_CTL_LEN),
                   .EXCEPT_LEN(EXCEPT_LEN), .LATENCY(LATENCY)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out),
        .ctl_i(ctl), .rs1_i(rs1), .rs2_i(rs2), .entry_idx_i(idx_in), .valid_o(valid_out),
        .ready_i(ready_in), .entry_idx_o(idx_out), .result_o(result),
        .except_raised_o(exc), .except_code_o(exc_code)
`ifdef FP_MISC_PIPE_FFLAGS_EN
        , .fflags_o(fflags)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] b, input logic [1:0] id, input logic [63:0] exp_res,
                          input logic exp_exc, input logic exp_nv);
        @(negedge clk);
        valid_in = 1'b1; ctl = c; rs1 = a; rs2 = b; idx_in = id;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        check({tag, ".valid"}, 64'(valid_out), 64'd1);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".idx"}, 64'(idx_out), 64'(id));
        check({tag, ".exc"}, 64'(exc), 64'(exp_exc));
        check({tag, ".code"}, 64'(exc_code), exp_exc ? 64'd1 : 64'd0);
`ifdef FP_MISC_PIPE_FFLAGS_EN
        check({tag, ".fflags"}, 64'(fflags), {59'd0, exp_nv, 4'b0000});
`else
        if (exp_nv) begin end
`endif
    endtask

    logic [63:0] bp_res [4];
    int          sent, got;
    logic        prev_stall;
    logic [63:0] held_res;
    logic [1:0]  held_idx;

    initial begin
        #2;
        check("reset.valid", 64'(valid_out), 64'd0);
        check("reset.result", result, 64'd0);
        check("reset.idx", 64'(idx_out), 64'd0);
        check("reset.exc", 64'(exc), 64'd0);
        check("reset.code", 64'(exc_code), 64'd0);
`ifdef FP_MISC_PIPE_FFLAGS_EN
        check("reset.fflags", 64'(fflags), 64'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset.ready", 64'(ready_out), 64'd1);

        run_op("fmin_zero",   4'd3, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_80000000, 2'd2, 64'hFFFFFFFF_80000000, 1'b0, 1'b0);
        run_op("fmin_qnan",   4'd3, 64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_40000000, 2'd1, 64'hFFFFFFFF_40000000, 1'b0, 1'b0);
        run_op("fmax_snan",   4'd4, 64'hFFFFFFFF_7F800001, 64'hFFFFFFFF_7F800001, 2'd3, 64'hFFFFFFFF_7FC00000, 1'b0, 1'b1);
        run_op("fmax_num",    4'd4, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_C0000000, 2'd0, 64'hFFFFFFFF_3F800000, 1'b0, 1'b0);
        run_op("flt_qnan",    4'd6, 64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_3F800000, 2'd1, 64'd0, 1'b0, 1'b1);
        run_op("feq_qnan",    4'd5, 64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_3F800000, 2'd2, 64'd0, 1'b0, 1'b0);
        run_op("fle_zeros",   4'd7, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_00000000, 2'd3, 64'd1, 1'b0, 1'b0);
        run_op("flt_zeros",   4'd6, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_00000000, 2'd0, 64'd0, 1'b0, 1'b0);
        run_op("flt_true",    4'd6, 64'hFFFFFFFF_C0000000, 64'hFFFFFFFF_3F800000, 2'd1, 64'd1, 1'b0, 1'b0);
        run_op("fclass_inf",  4'd8, 64'hFFFFFFFF_7F800000, 64'd0, 2'd2, 64'h80, 1'b0, 1'b0);
        run_op("fclass_unbx", 4'd8, 64'h00000000_3F800000, 64'd0, 2'd3, 64'h200, 1'b0, 1'b0);
        run_op("fsgnjn",      4'd1, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_3F800000, 2'd0, 64'hFFFFFFFF_BF800000, 1'b0, 1'b0);
        run_op("fsgnjx",      4'd2, 64'hFFFFFFFF_BF800000, 64'hFFFFFFFF_C0000000, 2'd1, 64'hFFFFFFFF_3F800000, 1'b0, 1'b0);
        run_op("fmv_x",       4'd9, 64'h12345678_BF800000, 64'd0, 2'd2, 64'hFFFFFFFF_BF800000, 1'b0, 1'b0);
        run_op("fmv_f",       4'd10, 64'h00000000_40490FDB, 64'd0, 2'd3, 64'hFFFFFFFF_40490FDB, 1'b0, 1'b0);
        run_op("illegal",     4'd12, 64'hFFFFFFFF_3F800000, 64'd0, 2'd1, 64'd0, 1'b1, 1'b0);

        // Back-pressure: four back-to-back FMV_F ops, output stalled for three cycles.
        for (int k = 0; k < 4; k++) bp_res[k] = {32'hFFFFFFFF, {8{4'(k + 1)}}};
        @(negedge clk);
        sent = 0; got = 0; prev_stall = 1'b0; held_res = '0; held_idx = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ready_in = !(cyc >= 2 && cyc <= 4);
            valid_in = (sent < 4);
            ctl      = 4'd10;
            rs1      = {32'd0, {8{4'(sent + 1)}}};
            idx_in   = 2'(sent);
            #1;
            if (prev_stall) begin
                check("bp.hold_valid", 64'(valid_out), 64'd1);
                check("bp.hold_result", result, held_res);
                check("bp.hold_idx", 64'(idx_out), 64'(held_idx));
            end
            if (valid_out && !ready_in) begin
                check("bp.ready_low", 64'(ready_out), 64'd0);
                prev_stall = 1'b1; held_res = result; held_idx = idx_out;
            end else begin
                prev_stall = 1'b0;
            end
            if (valid_out && ready_in) begin
                if (got < 4) begin
                    check("bp.result", result, bp_res[got]);
                    check("bp.idx", 64'(idx_out), 64'(got));
                end else begin
                    check("bp.extra", 64'(got), 64'd3);
                end
                got++;
            end
            if (valid_in && ready_out) sent++;
            @(negedge clk);
        end
        valid_in = 1'b0; ready_in = 1'b1;
        check("bp.sent", 64'(sent), 64'd4);
        check("bp.delivered", 64'(got), 64'd4);

        // Flush with two ops in flight and a third offered in the flush cycle.
        @(negedge clk);
        valid_in = 1'b1; ctl = 4'd10; rs1 = 64'h0000_0000_AAAA_0001; idx_in = 2'd1;
        @(negedge clk);
        rs1 = 64'h0000_0000_AAAA_0002; idx_in = 2'd2;
        @(negedge clk);
        rs1 = 64'h0000_0000_AAAA_0003; idx_in = 2'd3; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("flush.valid", 64'(valid_out), 64'd0);
            @(negedge clk);
        end

        run_op("post_flush",  4'd0, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_80000000, 2'd2, 64'hFFFFFFFF_BF800000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
